// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and sizing for the FIFO word serializer.
package ser_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned DEF_CNT_W  = 16;
    localparam int unsigned NB         = DEF_DATA_W / DEF_BYTE_W;
    localparam int unsigned BIDX_W     = $clog2(NB + 1);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPT,
        SEND
    } state_t;

    // Beat index width for a word of nb beats.
    function automatic int unsigned idx_w(input int unsigned nb);
        return (nb < 2) ? 1 : $clog2(nb + 1);
    endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO read port plus valid/ready byte stream seen by the serializer.
interface fifo_word_serializer_if
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) ();

    logic              fifo_empty;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_data;
    logic              m_valid;
    logic [BYTE_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic [CNT_W-1:0]  words_sent;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd, m_valid, m_data, m_last, busy, words_sent
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd, m_valid, m_data, m_last, busy, words_sent
    );

endinterface

// File: rtl/fifo_word_serializer_shift_reg.sv
// Word holding register with byte select; SER_PARITY_EN adds a running XOR beat.
module ser_shift_reg
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned IDX_W     = BIDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
`ifdef SER_PARITY_EN
    input  logic              step,
`endif
    input  logic [DATA_W-1:0] load_data,
    input  logic [IDX_W-1:0]  sel_idx,
    output logic [BYTE_W-1:0] byte_c
);

    localparam int unsigned NB_L = DATA_W / BYTE_W;

    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] src_c;
    logic [BYTE_W-1:0] data_byte_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= load_data;
        end
    end

    // The first beat is taken straight from the incoming word so it can be registered on load.
    assign src_c = load ? load_data : word_q;

    always_comb begin
        data_byte_c = '0;
        for (int unsigned k = 0; k < NB_L; k++) begin
            if (sel_idx == IDX_W'(k)) begin
                if (LSB_FIRST != 0) begin
                    data_byte_c = src_c[k*BYTE_W +: BYTE_W];
                end else begin
                    data_byte_c = src_c[DATA_W-(k+1)*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef SER_PARITY_EN
    logic [BYTE_W-1:0] par_q;

    // Accumulates every data byte as it is handed to the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= '0;
        end else if (load) begin
            par_q <= data_byte_c;
        end else if (step && (sel_idx < IDX_W'(NB_L))) begin
            par_q <= par_q ^ data_byte_c;
        end
    end

    assign byte_c = (sel_idx == IDX_W'(NB_L)) ? par_q : data_byte_c;
`else
    assign byte_c = data_byte_c;
`endif

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops 32-bit words from the FIFO and streams them out as bytes; SER_PARITY_EN appends an XOR beat.
module fifo_word_serializer
    import ser_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned LSB_FIRST = 1,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fifo_word_serializer_if.master bus
);

    localparam int unsigned NB_L   = DATA_W / BYTE_W;
`ifdef SER_PARITY_EN
    localparam int unsigned NBEATS = NB_L + 1;
`else
    localparam int unsigned NBEATS = NB_L;
`endif
    localparam int unsigned IDX_W  = idx_w(NBEATS);

    state_t            state;
    logic [IDX_W-1:0]  beat_idx;
    logic [IDX_W-1:0]  sel_idx_c;
    logic [BYTE_W-1:0] byte_c;
    logic              load_c;
    logic              accept_c;
    logic              last_beat_c;
    logic              step_c;

    assign accept_c    = bus.m_valid && bus.m_ready;
    assign last_beat_c = (beat_idx == IDX_W'(NBEATS - 1));
    assign load_c      = (state == CAPT);
    assign step_c      = (state == SEND) && accept_c && !last_beat_c;
    assign sel_idx_c   = load_c ? '0 : beat_idx + IDX_W'(1);

    ser_shift_reg #(
        .DATA_W    (DATA_W),
        .BYTE_W    (BYTE_W),
        .LSB_FIRST (LSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
`ifdef SER_PARITY_EN
        .step      (step_c),
`endif
        .load_data (bus.fifo_data),
        .sel_idx   (sel_idx_c),
        .byte_c    (byte_c)
    );

    // Control FSM with registered outputs; fifo_rd is a one-cycle strobe aligned with POP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat_idx       <= '0;
            bus.fifo_rd    <= 1'b0;
            bus.m_valid    <= 1'b0;
            bus.m_data     <= '0;
            bus.m_last     <= 1'b0;
            bus.busy       <= 1'b0;
            bus.words_sent <= '0;
        end else begin
            bus.fifo_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.fifo_empty) begin
                        state       <= POP;
                        bus.fifo_rd <= 1'b1;
                        bus.busy    <= 1'b1;
                    end
                end
                POP: begin
                    state <= CAPT;
                end
                CAPT: begin
                    beat_idx    <= '0;
                    bus.m_data  <= byte_c;
                    bus.m_last  <= (NBEATS == 1);
                    bus.m_valid <= 1'b1;
                    state       <= SEND;
                end
                SEND: begin
                    if (accept_c) begin
                        if (last_beat_c) begin
                            bus.words_sent <= bus.words_sent + CNT_W'(1);
                            bus.m_valid    <= 1'b0;
                            bus.m_last     <= 1'b0;
                            bus.m_data     <= '0;
                            if (!bus.fifo_empty) begin
                                state       <= POP;
                                bus.fifo_rd <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            beat_idx   <= beat_idx + IDX_W'(1);
                            bus.m_data <= byte_c;
                            bus.m_last <= (beat_idx == IDX_W'(NBEATS - 2));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: FIFO model, byte scoreboard, handshake and timing checks.
module tb_fifo_word_serializer;
    import ser_pkg::*;

    localparam int unsigned DW  = 32;
    localparam int unsigned BW  = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned NBT = DW / BW;
`ifdef SER_PARITY_EN
    localparam int unsigned BEATS = NBT + 1;
`else
    localparam int unsigned BEATS = NBT;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ready_t = 1'b1;
    logic [DW-1:0] fdata = '0;
    int            fifo_cnt = 0;
    int            pop_cnt = 0;
    int            exp_words = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    logic [DW-1:0] fifo_q[$];
    logic [BW:0]   exp_q[$];

    logic          prev_stall = 1'b0;
    logic          prev_rd = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always #5 clk = ~clk;

    fifo_word_serializer_if #(.DATA_W(DW), .BYTE_W(BW), .CNT_W(CW)) bus ();

    assign bus.fifo_empty = (fifo_cnt == 0);
    assign bus.fifo_data  = fdata;
    assign bus.m_ready    = ready_t;

    fifo_word_serializer #(
        .DATA_W    (DW),
        .BYTE_W    (BW),
        .LSB_FIRST (1),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the word in the FIFO model and its expected beats in the scoreboard.
    task automatic push_word(input logic [DW-1:0] w);
        logic [BW-1:0] b;
        logic [BW-1:0] par;
        par = '0;
        fifo_q.push_back(w);
        fifo_cnt++;
        for (int k = 0; k < int'(NBT); k++) begin
            b = w[k*BW +: BW];
            par = par ^ b;
            exp_q.push_back({(k == int'(NBT) - 1) && (BEATS == NBT), b});
        end
`ifdef SER_PARITY_EN
        exp_q.push_back({1'b1, par});
`endif
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 500) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(t < 500), 1);
    endtask

    // Output monitor and FIFO read model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [BW:0] e;
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.m_valid), 1);
                check("hold_data", 32'(bus.m_data), 32'(prev_data));
                check("hold_last", 32'(bus.m_last), 32'(prev_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(bus.m_data), 32'(e[BW-1:0]));
                    check("beat_last", 32'(bus.m_last), 32'(e[BW]));
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
            if (bus.fifo_rd) begin
                check("rd_nonempty", 32'(fifo_cnt != 0), 1);
                check("rd_single", 32'(prev_rd), 0);
                pop_cnt++;
                if (fifo_cnt != 0) begin
                    fdata = fifo_q.pop_front();
                    fifo_cnt--;
                end
            end
            prev_rd = bus.fifo_rd;
        end else begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 0);
        check("rst_fifo_rd", 32'(bus.fifo_rd), 0);
        check("rst_m_data", 32'(bus.m_data), 0);
        check("rst_m_last", 32'(bus.m_last), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_words_sent", 32'(bus.words_sent), 0);
        rst_n = 1'b1;
        tick();

        // Single word, latency and byte order
        s = pop_cnt;
        push_word(32'h11223344);
        tick();
        tick();
        check("lat_not_yet", 32'(bus.m_valid), 0);
        tick();
        check("lat_first_valid", 32'(bus.m_valid), 1);
        check("lat_first_byte", 32'(bus.m_data), 32'h44);
        drain();
        exp_words += 1;
        check("t1_words_sent", 32'(bus.words_sent), 32'(exp_words));
        check("t1_pops", 32'(pop_cnt - s), 1);
        check("t1_busy", 32'(bus.busy), 0);

        // Back-to-back words with two-cycle bubbles
        s = pop_cnt;
        push_word(32'hA0A1A2A3);
        push_word(32'hB0B1B2B3);
        push_word(32'hC0C1C2C3);
        repeat (3 * BEATS + 6) tick();
        check("b2b_last_valid", 32'(bus.m_valid), 1);
        check("b2b_last_flag", 32'(bus.m_last), 1);
        check("b2b_busy_hi", 32'(bus.busy), 1);
        tick();
        check("b2b_idle_busy", 32'(bus.busy), 0);
        check("b2b_idle_valid", 32'(bus.m_valid), 0);
        exp_words += 3;
        check("b2b_words_sent", 32'(bus.words_sent), 32'(exp_words));
        check("b2b_sb_empty", 32'(exp_q.size()), 0);
        check("b2b_pops", 32'(pop_cnt - s), 3);

        // Stall mid-word with another word waiting in the FIFO
        s = pop_cnt;
        push_word(32'hDEADBEEF);
        push_word(32'h01020304);
        repeat (4) tick();
        check("stall_pre_data", 32'(bus.m_data), 32'hBE);
        ready_t = 1'b0;
        repeat (10) tick();
        check("stall_valid", 32'(bus.m_valid), 1);
        check("stall_data", 32'(bus.m_data), 32'hBE);
        check("stall_last", 32'(bus.m_last), 0);
        check("stall_no_pop", 32'(pop_cnt - s), 1);
        ready_t = 1'b1;
        drain();
        exp_words += 2;
        check("stall_words_sent", 32'(bus.words_sent), 32'(exp_words));
        check("stall_pops", 32'(pop_cnt - s), 2);

        // Empty FIFO: nothing happens
        s = pop_cnt;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("empty_no_rd", 32'(bus.fifo_rd), 0);
            check("empty_no_valid", 32'(bus.m_valid), 0);
        end
        check("empty_pops", 32'(pop_cnt - s), 0);

        // Asynchronous reset during beat 2 drops the word
        s = pop_cnt;
        push_word(32'hCAFEF00D);
        repeat (5) tick();
        check("rstmid_beat2", 32'(bus.m_data), 32'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 32'(bus.m_valid), 0);
        check("rstmid_data", 32'(bus.m_data), 0);
        check("rstmid_last", 32'(bus.m_last), 0);
        check("rstmid_busy", 32'(bus.busy), 0);
        check("rstmid_words", 32'(bus.words_sent), 0);
        check("rstmid_rd", 32'(bus.fifo_rd), 0);
        exp_q.delete();
        exp_words = 0;
        tick();
        rst_n = 1'b1;
        tick();
        push_word(32'h0BADC0DE);
        repeat (3) tick();
        check("rstmid_next_valid", 32'(bus.m_valid), 1);
        check("rstmid_next_beat0", 32'(bus.m_data), 32'hDE);
        drain();
        exp_words += 1;
        check("rstmid_words_after", 32'(bus.words_sent), 32'(exp_words));
        check("rstmid_pops", 32'(pop_cnt - s), 2);

`ifdef SER_PARITY_EN
        // Parity beat after the data bytes
        push_word(32'hA5A50F0F);
        repeat (3 + NBT) tick();
        check("par_last_flag", 32'(bus.m_last), 1);
        check("par_beat", 32'(bus.m_data), 32'h00);
        drain();
        exp_words += 1;
        check("par_words_sent", 32'(bus.words_sent), 32'(exp_words));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
